brnch_resolve_unit: RTL



---
 rtl/selen_brnch_pkg.sv | 34 +++
 rtl/brnch_bht.sv | 43 ++++
 rtl/brnch_resolve_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/selen_brnch_pkg.sv
// rtl/selen_brnch_pkg.sv - shared constants and types for the branch resolve unit
// Contents: condition codes, FSM state encoding, BHT counter constants and the
// saturating counter step function.
package selen_brnch_pkg;

    localparam logic [2:0] COND_EQ  = 3'b000;
    localparam logic [2:0] COND_NE  = 3'b001;
    localparam logic [2:0] COND_LT  = 3'b010;
    localparam logic [2:0] COND_GE  = 3'b011;
    localparam logic [2:0] COND_LTU = 3'b100;
    localparam logic [2:0] COND_GEU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RESOLVE  = 2'b01,
        ST_REDIRECT = 2'b10
    } brnch_state_e;

    localparam logic [1:0] CNT_MIN = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_MAX = 2'b11;

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != CNT_MAX) begin
            res = cnt + 2'd1;
        end else if (!taken && cnt != CNT_MIN) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/brnch_bht.sv
// rtl/brnch_bht.sv - bimodal table of 2-bit saturating counters
// Ports: clk, rst (sync, active-high); rd_idx/rd_taken combinational lookup;
// wr_en/wr_idx/wr_taken saturating update at the clock edge.
module brnch_bht
    import selen_brnch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    // Read uses the registered array only, so a same-cycle write is not visible.
    assign rd_taken = cnt_q[rd_idx][1];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = cnt_next(cnt_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/brnch_resolve_unit.sv
// rtl/brnch_resolve_unit.sv - branch condition resolve, mispredict redirect and BHT owner
// Ports: clk, rst (sync, active-high); ex_* branch input with valid/ready;
// redirect_* handshake to fetch plus flush pulse; if_pc/if_pred_taken BHT lookup.
// Optional BRNCH_STAT_EN adds saturating stat_branches / stat_mispred counters.
module brnch_resolve_unit
    import selen_brnch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int PC_LSB    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_op_a,
    input  logic [XLEN-1:0] ex_op_b,
    input  logic [2:0]      ex_cond,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken
`ifdef BRNCH_STAT_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    brnch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [2:0]      cond_q, cond_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            pred_q, pred_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            in_resolve;
    logic            taken;
    logic            cond_legal;
    logic            mispredict;
    logic            accept;
    logic [XLEN-1:0] next_pc;
    logic            unused_if_pc;

    assign unused_if_pc = ^if_pc;

    always_comb begin
        taken = 1'b0;
        case (cond_q)
            COND_EQ:  taken = (op_a_q == op_b_q);
            COND_NE:  taken = (op_a_q != op_b_q);
            COND_LT:  taken = ($signed(op_a_q) <  $signed(op_b_q));
            COND_GE:  taken = ($signed(op_a_q) >= $signed(op_b_q));
            COND_LTU: taken = (op_a_q <  op_b_q);
            COND_GEU: taken = (op_a_q >= op_b_q);
            default:  taken = 1'b0;
        endcase
    end

    assign cond_legal = (cond_q[2:1] != 2'b11);
    assign in_resolve = (state_q == ST_RESOLVE);
    assign mispredict = taken ^ pred_q;
    assign next_pc    = taken ? target_q : pc_q + XLEN'(4);

    // Gated by rst so a reset landing in REDIRECT can never complete a handshake.
    assign redirect_valid = !rst && ((in_resolve && mispredict) || (state_q == ST_REDIRECT));
    assign redirect_pc    = in_resolve ? next_pc : redirect_pc_q;
    assign flush          = redirect_valid && redirect_ready;
    assign ex_ready       = (state_q == ST_IDLE) || (in_resolve && !mispredict);
    assign accept         = ex_valid && ex_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        cond_d        = cond_q;
        target_d      = target_q;
        pred_d        = pred_q;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (mispredict) begin
                    redirect_pc_d = next_pc;
                    state_d       = flush ? ST_IDLE : ST_REDIRECT;
                end else begin
                    state_d = accept ? ST_RESOLVE : ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (flush) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            pc_d     = ex_pc;
            op_a_d   = ex_op_a;
            op_b_d   = ex_op_b;
            cond_d   = ex_cond;
            target_d = ex_target;
            pred_d   = ex_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            cond_q        <= COND_EQ;
            target_q      <= '0;
            pred_q        <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            cond_q        <= cond_d;
            target_q      <= target_d;
            pred_q        <= pred_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    brnch_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[PC_LSB +: BHT_IDX_W]),
        .rd_taken (if_pred_taken),
        .wr_en    (in_resolve && cond_legal),
        .wr_idx   (pc_q[PC_LSB +: BHT_IDX_W]),
        .wr_taken (taken)
    );

`ifdef BRNCH_STAT_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (in_resolve && stat_branches_q != 32'hFFFF_FFFF) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (in_resolve && mispredict && stat_mispred_q != 32'hFFFF_FFFF) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule
